// File: rtl/alu_share_arbiter.sv
// Two-port valid/ready arbiter in front of a single combinational RV32I ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; winner accepted on valid && ready
// EXEC  | ALU evaluates the registered operands; result captured
// RESP  | result held for the granted requester until its rsp_ready
module alu_share_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [WIDTH-1:0]  r0_a,
   input  logic [WIDTH-1:0]  r0_b,
   input  logic [CTRL_W-1:0] r0_ctrl,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,
   output logic [WIDTH-1:0]  r0_result,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [WIDTH-1:0]  r1_a,
   input  logic [WIDTH-1:0]  r1_b,
   input  logic [CTRL_W-1:0] r1_ctrl,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,
   output logic [WIDTH-1:0]  r1_result,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]  alu_result,
   output logic              busy,
   output logic              grant_id
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              winner, accept, rsp_ready_g;
`ifdef ALU_ARB_RR_EN
   logic              ptr_q, ptr_d;
`endif

   // Winner is only meaningful when its own valid is high; ready is gated by valid.
   always_comb begin
`ifdef ALU_ARB_RR_EN
      winner = (r0_valid && r1_valid) ? ptr_q : r1_valid;
`else
      winner = !r0_valid;
`endif
   end

   assign accept      = (state_q == S_IDLE) && (winner ? r1_valid : r0_valid);
   assign rsp_ready_g = grant_q ? r1_rsp_ready : r0_rsp_ready;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      ctrl_d   = ctrl_q;
      result_d = result_q;
`ifdef ALU_ARB_RR_EN
      ptr_d    = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               alu_a_d = winner ? r1_a    : r0_a;
               alu_b_d = winner ? r1_b    : r0_b;
               ctrl_d  = winner ? r1_ctrl : r0_ctrl;
               grant_d = winner;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            result_d = alu_result;
            state_d  = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready_g) begin
               state_d = S_IDLE;
`ifdef ALU_ARB_RR_EN
               ptr_d   = !grant_q;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         grant_q  <= 1'b0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         ctrl_q   <= '0;
         result_q <= '0;
`ifdef ALU_ARB_RR_EN
         ptr_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         ctrl_q   <= ctrl_d;
         result_q <= result_d;
`ifdef ALU_ARB_RR_EN
         ptr_q    <= ptr_d;
`endif
      end
   end

   assign r0_ready     = (state_q == S_IDLE) && r0_valid && !winner;
   assign r1_ready     = (state_q == S_IDLE) && r1_valid && winner;
   assign r0_rsp_valid = (state_q == S_RESP) && !grant_q;
   assign r1_rsp_valid = (state_q == S_RESP) && grant_q;
   assign r0_result    = result_q;
   assign r1_result    = result_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign alu_control  = ctrl_q;
   assign busy         = (state_q != S_IDLE);
   assign grant_id     = grant_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed test-plan steps plus random traffic against a
// transaction-level model (winner rule, 2-cycle latency, backpressure hold, reset abort).
module tb_alu_share_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
   logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
   logic [31:0] r0_a, r0_b, r0_result, r1_a, r1_b, r1_result;
   logic [3:0]  r0_ctrl, r1_ctrl, alu_control;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        busy, grant_id;

   int checks = 0;
   int errors = 0;
`ifdef ALU_ARB_RR_EN
   bit exp_ptr = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_ctrl(r0_ctrl),
      .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_ctrl(r1_ctrl),
      .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
      .busy(busy), .grant_id(grant_id)
   );

   // Stand-in for the RV32I ALU; codes 1110/1111 return zero.
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
      logic [31:0] r;
      case (c)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a << b[4:0];
         4'd3:  r = {31'b0, $signed(a) < $signed(b)};
         4'd4:  r = {31'b0, a < b};
         4'd5:  r = a ^ b;
         4'd6:  r = a >> b[4:0];
         4'd7:  r = $signed(a) >>> b[4:0];
         4'd8:  r = a | b;
         4'd9:  r = a & b;
         4'd10: r = b;
         4'd11: r = a + b;
         4'd12: r = {31'b0, a == b};
         4'd13: r = {31'b0, a != b};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   assign alu_result = alu_ref(alu_a, alu_b, alu_control);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete operation starting in an IDLE cycle; the loser's valid is raised after
   // acceptance to confirm nothing else is accepted until the response completes.
   task automatic txn(input bit v0, input bit v1,
                      input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                      input int bp, output bit w, output logic [31:0] got);
      logic [31:0] ea, eb, er;
      logic [3:0]  ec;
`ifdef ALU_ARB_RR_EN
      w = (v0 && v1) ? exp_ptr : (v1 && !v0);
`else
      w = v1 && !v0;
`endif
      r0_valid = v0; r0_a = a0; r0_b = b0; r0_ctrl = c0;
      r1_valid = v1; r1_a = a1; r1_b = b1; r1_ctrl = c1;
      r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
      ea = w ? a1 : a0;
      eb = w ? b1 : b0;
      ec = w ? c1 : c0;
      er = alu_ref(ea, eb, ec);
      #1;
      chk("idle_busy", busy, 0);
      chk("accept_r0_ready", r0_ready, !w);
      chk("accept_r1_ready", r1_ready, w);
      @(posedge clk); #1;
      if (w) begin r1_valid = 1'b0; r0_valid = 1'b1; end
      else   begin r0_valid = 1'b0; r1_valid = 1'b1; end
      #1;
      chk("exec_busy", busy, 1);
      chk("exec_ready", {r0_ready, r1_ready}, 0);
      chk("exec_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
      chk("exec_grant", grant_id, w);
      chk("exec_alu_a", alu_a, ea);
      chk("exec_alu_b", alu_b, eb);
      chk("exec_alu_ctrl", alu_control, ec);
      @(posedge clk); #1;
      for (int i = 0; i < bp; i++) begin
         if (w) r0_rsp_ready = 1'b1; else r1_rsp_ready = 1'b1;
         #1;
         chk("bp_rsp_valid", {r1_rsp_valid, r0_rsp_valid}, w ? 2'b10 : 2'b01);
         chk("bp_result", w ? r1_result : r0_result, er);
         chk("bp_ready", {r0_ready, r1_ready}, 0);
         @(posedge clk); #1;
      end
      r0_rsp_ready = !w; r1_rsp_ready = w;
      #1;
      chk("resp_valid", {r1_rsp_valid, r0_rsp_valid}, w ? 2'b10 : 2'b01);
      chk("resp_result", w ? r1_result : r0_result, er);
      chk("resp_grant", grant_id, w);
      chk("resp_ready", {r0_ready, r1_ready}, 0);
      got = w ? r1_result : r0_result;
      @(posedge clk); #1;
      r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
      chk("done_busy", busy, 0);
      chk("done_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
      chk("done_alu_a_held", alu_a, ea);
`ifdef ALU_ARB_RR_EN
      exp_ptr = !w;
`endif
   endtask

   bit          g;
   bit          gseq[4];
   logic [31:0] got;
   int          sel;

   initial begin
      rst = 1'b1;
      r0_valid = 0; r0_a = 0; r0_b = 0; r0_ctrl = 0; r0_rsp_ready = 0;
      r1_valid = 0; r1_a = 0; r1_b = 0; r1_ctrl = 0; r1_rsp_ready = 0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_ready", {r0_ready, r1_ready}, 0);
      chk("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_result", r0_result, 0);
      chk("rst_grant", grant_id, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Single ADD from requester 0
      txn(1, 0, 32'd5, 32'd7, 4'b0000, 0, 0, 0, 0, g, got);
      chk("single_grant", g, 0);
      chk("single_result", got, 32'd12);
      r0_valid = 0; r1_valid = 0;
      @(posedge clk); #1;

      // Requester 1 SUB with 4 cycles of backpressure while r0 is also requesting
      txn(0, 1, 0, 0, 0, 32'h10, 32'd3, 4'b0001, 4, g, got);
      chk("bp_grant", g, 1);
      chk("bp_final_result", got, 32'h0D);
      r0_valid = 0; r1_valid = 0;
      @(posedge clk); #1;

      // Continuous contention, back to back with no idle gap between operations
      for (int k = 0; k < 4; k++) begin
         txn(1, 1, 32'd1, 32'd4, 4'b0010, 32'hF0, 32'hFF, 4'b0101, 0, g, got);
         gseq[k] = g;
         chk("cont_result", got, g ? 32'h0F : 32'h10);
      end
`ifdef ALU_ARB_RR_EN
      chk("rr_first", gseq[0], 0);
      for (int k = 1; k < 4; k++) chk("rr_alternate", gseq[k], !gseq[k-1]);
`else
      for (int k = 0; k < 4; k++) chk("fixed_r0_wins", gseq[k], 0);
`endif
      // r0 drops: r1 served in the very next IDLE cycle
      txn(0, 1, 32'd1, 32'd4, 4'b0010, 32'hF0, 32'hFF, 4'b0101, 0, g, got);
      chk("r1_after_r0_drop", g, 1);
      chk("r1_after_drop_result", got, 32'h0F);
      r0_valid = 0; r1_valid = 0;
      @(posedge clk); #1;

      // Undefined control code passes through; ALU returns zero
      txn(1, 0, 32'd9, 32'd9, 4'b1111, 0, 0, 0, 0, g, got);
      chk("undef_result", got, 32'd0);
      r0_valid = 0; r1_valid = 0;
      @(posedge clk); #1;

      // Reset during EXEC discards the operation
      r0_valid = 1; r0_a = 32'd2; r0_b = 32'd2; r0_ctrl = 4'b0000;
      #1;
      chk("rst_op_ready", r0_ready, 1);
      @(posedge clk); #1;
      r0_valid = 0;
      chk("rst_op_in_exec", busy, 1);
      rst = 1'b1;
      #1;
      chk("async_busy", busy, 0);
      chk("async_ready", {r0_ready, r1_ready}, 0);
      chk("async_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
      chk("async_alu", {alu_a, alu_b}, 0);
      chk("async_ctrl", alu_control, 0);
      chk("async_grant", grant_id, 0);
      chk("async_result", r1_result, 0);
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef ALU_ARB_RR_EN
      exp_ptr = 1'b0;
`endif
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("post_rst_no_rsp", {busy, r0_rsp_valid, r1_rsp_valid}, 0);
      end
      txn(0, 1, 0, 0, 0, 32'd1, 32'd1, 4'b0000, 0, g, got);
      chk("post_rst_result", got, 32'd2);
      r0_valid = 0; r1_valid = 0;
      @(posedge clk); #1;

      // Random traffic
      for (int k = 0; k < 20; k++) begin
         sel = $urandom_range(1, 3);
         txn(sel[0], sel[1], $urandom, $urandom, 4'($urandom_range(0, 15)),
             $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), g, got);
         r0_valid = 0; r1_valid = 0;
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational RV32I ALU between two requesters (port 0: main execute path; port 1: address/branch-compare helper) using valid/ready handshakes. Accepts one operation at a time, drives the registered operands and control code into the ALU, captures the result and returns it to the granted requester. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

## Interface
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU control code width (codes 0000–1101 defined by the ALU; others yield 0)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rN_valid  in  1  requester N (N=0,1) operation valid
- rN_ready  out  1  requester N operation accepted this cycle
- rN_a, rN_b  in  WIDTH  operands A, B
- rN_ctrl  in  CTRL_W  ALU control code
- rN_rsp_valid  out  1  result valid for requester N
- rN_rsp_ready  in  1  requester N consumes result
- rN_result  out  WIDTH  result (shared result register, qualified by rN_rsp_valid)
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_control  out  CTRL_W  registered control code to ALU
- alu_result  in  WIDTH  combinational ALU output
- busy  out  1  high in EXEC or RESP
- grant_id  out  1  requester owning the current operation

## Operation
- States: IDLE, EXEC, RESP. Reset: IDLE, all outputs 0, priority pointer = requester 0.
- IDLE: winner chosen combinationally from r0_valid/r1_valid; rN_ready = (state==IDLE) && winner==N; loser's ready 0. Handshake (valid&&ready) latches a, b, ctrl into alu_a/alu_b/alu_control, winner into grant_id; → EXEC. No valid: stay IDLE.
- EXEC (one cycle): ALU evaluates registered operands; alu_result captured into result register; → RESP.
- RESP: r{grant_id}_rsp_valid=1, other rsp_valid=0; rN_result both driven from result register. Hold until r{grant_id}_rsp_ready=1; then → IDLE and priority pointer = other requester. rsp_ready on non-granted port ignored.
- No new acceptance in EXEC or RESP (both rN_ready=0), including the cycle RESP completes.
- Requesters hold valid, a, b, ctrl stable until ready; arbiter does not check.
- Undefined ctrl codes (1110, 1111) pass through; response value is whatever ALU returns (0); no error flag.
- Result width equals WIDTH; no truncation or extension in this block.
- alu_a/alu_b/alu_control keep last operation's values in IDLE (no toggling).

## Timing
- Accept at edge T (end of IDLE cycle) → EXEC in cycle T+1 → rsp_valid high in cycle T+2. Latency accept→rsp_valid: 2 cycles.
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with immediate rsp_ready).
- Backpressure: rsp_valid and result stable while rsp_ready low, any number of cycles.
- Simultaneous valids in IDLE: pointer decides winner; after completion the loser wins next if still valid.
- Reset mid-EXEC/RESP: operation discarded, no response issued, all outputs 0 immediately (async), pointer = 0.

## Configuration
- ALU_ARB_RR_EN defined: round-robin as above (pointer toggles after each completed response).
- Not defined: fixed priority, requester 0 always wins simultaneous requests; pointer logic removed; requester 1 served only when r0_valid=0 in IDLE.

## Test plan
- Single op: r0 a=5, b=7, ctrl=0000 → r0_ready in accept cycle, r0_rsp_valid 2 cycles later, r0_result=12, grant_id=0; r1_rsp_valid stays 0.
- Backpressure: r1 a=0x10, b=3, ctrl=0001, r1_rsp_ready low 4 cycles → r1_rsp_valid held, r1_result=0x0D stable; r0_ready=0 throughout despite r0_valid=1.
- Contention (ALU_ARB_RR_EN): both valid continuously, r0 ctrl=0010 a=1 b=4, r1 ctrl=0101 a=0xF0 b=0xFF → grants alternate 0,1,0,1; results 0x10 and 0x0F; issue every 3 cycles.
- Fixed priority (macro undefined): same stimulus → r0 always granted, r1 never while r0_valid=1; r1 served first cycle r0_valid drops.
- Reset mid-op: assert rst during EXEC of r0 ADD 2+2 → all outputs 0 asynchronously, no rsp_valid after release; next op r1 ADD 1+1 returns 2 with normal latency.
- Undefined ctrl 1111, a=9, b=9 → response delivered with result 0, normal latency.
